dtc_feature_driver: RTL

- Drives feature vectors into a combinational decision-tree classifier (12-bit feature word in, 3-bit class out) and returns the labelled results.
- Accepts features on a valid/ready stream, holds them stable on the classifier input for a programmable settle time, then samples the class. Emits {feature, class} on an output valid/ready stream.
- Keeps saturating per-class hit counters for on-chip accuracy and distribution checks.
- Sits between the feature source (DMA or test stimulus) and any dtc_* classifier instance.

---
 rtl/dtc_feature_driver_if.sv | 27 ++
 rtl/dtc_feature_driver.sv | 135 +++++++++++++
 2 files changed

// File: rtl/dtc_feature_driver_if.sv
// Stream bundle between a feature source / result sink and dtc_feature_driver.
//   s_valid/s_ready/s_data  : feature word stream into the driver
//   m_valid/m_ready/m_feat/m_class : labelled result stream out of the driver
// master: environment side (drives s_valid, s_data, m_ready)
// slave : driver side (drives s_ready, m_valid, m_feat, m_class)
interface dtc_feature_driver_if #(
  parameter int unsigned IN_W  = 12,
  parameter int unsigned OUT_W = 3
);
  logic             s_valid;
  logic             s_ready;
  logic [IN_W-1:0]  s_data;
  logic             m_valid;
  logic             m_ready;
  logic [IN_W-1:0]  m_feat;
  logic [OUT_W-1:0] m_class;

  modport master (
    output s_valid, output s_data, output m_ready,
    input  s_ready, input  m_valid, input  m_feat, input m_class
  );

  modport slave (
    input  s_valid, input  s_data, input  m_ready,
    output s_ready, output m_valid, output m_feat, output m_class
  );
endinterface

// File: rtl/dtc_feature_driver.sv
// Drives feature words into a combinational decision-tree classifier, waits a
// programmable settle time, samples the class and returns {feature, class}.
// Keeps saturating per-class hit counters.
// Ports:
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   bus       : slave side of the feature/result streams
//   dtc_inp   : registered feature word to the classifier
//   dtc_outp  : classifier result (combinational from dtc_inp)
//   busy      : high whenever the FSM is not idle
//   cnt_sel   : counter select; cnt_val shows counter[cnt_sel] combinationally
//   cnt_clr   : synchronous clear of all counters
module dtc_feature_driver #(
  parameter int unsigned IN_W   = 12,
  parameter int unsigned OUT_W  = 3,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  dtc_feature_driver_if.slave  bus,
  output logic [IN_W-1:0]      dtc_inp,
  input  logic [OUT_W-1:0]     dtc_outp,
  output logic                 busy,
  input  logic [OUT_W-1:0]     cnt_sel,
  output logic [CNT_W-1:0]     cnt_val,
  input  logic                 cnt_clr
);

  localparam int unsigned      NCLS    = 1 << OUT_W;
  localparam int unsigned      WCNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q;
  logic [WCNT_W-1:0]  wcnt_q;
  logic [IN_W-1:0]    inp_q;
  logic [IN_W-1:0]    feat_q;
  logic [OUT_W-1:0]   class_q;
  logic               mvalid_q;
  logic               sready_q;
  logic               busy_q;
  logic [CNT_W-1:0]   cnt_q [NCLS];
  logic [CNT_W-1:0]   cnt_d [NCLS];
  logic               capture_c;

  // Capture fires on the last WAIT cycle; a zero settle still takes one WAIT
  // cycle so the classifier sees the freshly registered word.
  assign capture_c = (state_q == WAIT) && (wcnt_q == '0);

  // Control FSM and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      inp_q    <= '0;
      feat_q   <= '0;
      class_q  <= '0;
      mvalid_q <= 1'b0;
      sready_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          sready_q <= 1'b1;
          if (bus.s_valid && sready_q) begin
            inp_q    <= bus.s_data;
            wcnt_q   <= WCNT_W'(SETTLE);
            sready_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (wcnt_q != '0) begin
            wcnt_q <= wcnt_q - WCNT_W'(1);
          end else begin
            class_q  <= dtc_outp;
            feat_q   <= inp_q;
            mvalid_q <= 1'b1;
            state_q  <= RESP;
          end
        end
        RESP: begin
          if (bus.m_ready) begin
            mvalid_q <= 1'b0;
            sready_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          mvalid_q <= 1'b0;
          sready_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  // Counter update: clear first, then a coinciding capture counts from zero
  always_comb begin
    for (int unsigned i = 0; i < NCLS; i++) begin
      cnt_d[i] = cnt_clr ? '0 : cnt_q[i];
      if (capture_c && (dtc_outp == OUT_W'(i)) && (cnt_d[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_d[i] + CNT_W'(1);
      end
    end
  end

  // Per-class hit counters
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCLS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.s_ready = sready_q;
  assign bus.m_valid = mvalid_q;
  assign bus.m_feat  = feat_q;
  assign bus.m_class = class_q;
  assign dtc_inp     = inp_q;
  assign busy        = busy_q;
  assign cnt_val     = cnt_q[cnt_sel];

endmodule
